// File: rtl/lc3_memory_responder.sv
// LC-3 MIO memory responder: wait-stated access to a word array, Ready pulse on completion.
// Optional memory-mapped keyboard/display device space when LC3_MMIO_EN is defined.
module lc3_memory_responder #(
   parameter int    MEM_ADDR_BITS = 10,
   parameter int    WAIT_STATES   = 3,
   parameter string INIT_FILE     = ""
) (
   input  logic        i_clk,
   input  logic        i_Reset_n,
   input  logic        i_MIO_EN,
   input  logic        i_R_W,
   input  logic [15:0] i_MAR,
   input  logic [15:0] i_MDR,
   output logic [15:0] o_Mem_Data,
   output logic        o_Ready_Bit,
   output logic        o_Busy
`ifdef LC3_MMIO_EN
   ,
   input  logic        i_KB_valid,
   input  logic [7:0]  i_KB_data,
   input  logic        i_Disp_ready,
   output logic        o_Disp_valid,
   output logic [7:0]  o_Disp_data
`endif
);

   // state | meaning
   // IDLE  | waiting for i_MIO_EN; accepts and latches the request
   // WAIT  | counting down wait states; i_MIO_EN low aborts
   // READY | Ready pulse; write commits, read data loaded on entry
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_READY = 2'd2;
   localparam int         DEPTH   = 1 << MEM_ADDR_BITS;

   logic [15:0] r_mem [0:DEPTH-1];

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;
   logic [3:0]  r_count;
   logic [15:0] r_addr;
   logic [15:0] r_data;
   logic        r_rw;
   logic [15:0] r_mem_data;

   logic [15:0] w_acc_addr;
   logic        w_acc_rw;
   logic [15:0] w_rd_data;
   logic        w_load_read;
   logic        w_commit;

   // Array contents survive reset; they are only set up at configuration time.
   initial begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_MIO_EN) w_next_state = (WAIT_STATES == 0) ? S_READY : S_WAIT;
         end
         S_WAIT: begin
            if (!i_MIO_EN)          w_next_state = S_IDLE;
            else if (r_count == 4'd1) w_next_state = S_READY;
         end
         S_READY: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // With zero wait states READY follows IDLE directly, so the live request is used.
   assign w_acc_addr  = (r_state == S_IDLE) ? i_MAR : r_addr;
   assign w_acc_rw    = (r_state == S_IDLE) ? i_R_W : r_rw;
   assign w_load_read = (w_next_state == S_READY) && !w_acc_rw;

   always_ff @(posedge i_clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_rw       <= 1'b0;
         r_mem_data <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_IDLE && i_MIO_EN) begin
            r_addr  <= i_MAR;
            r_data  <= i_MDR;
            r_rw    <= i_R_W;
            r_count <= 4'(WAIT_STATES);
         end else if (r_state == S_WAIT && r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
         end
         if (w_load_read) r_mem_data <= w_rd_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_commit) r_mem[r_addr[MEM_ADDR_BITS-1:0]] <= r_data;
   end

   assign o_Mem_Data  = r_mem_data;
   assign o_Ready_Bit = (r_state == S_READY);
   assign o_Busy      = (r_state != S_IDLE);

`ifdef LC3_MMIO_EN
   logic       r_kb_full;
   logic [7:0] r_kb_data;
   logic       w_acc_dev;
   logic       w_lat_dev;
   logic       w_kb_clear;

   assign w_acc_dev  = &w_acc_addr[15:9];
   assign w_lat_dev  = &r_addr[15:9];
   assign w_commit   = (r_state == S_READY) && r_rw && !w_lat_dev;
   assign w_kb_clear = (r_state == S_READY) && !r_rw && (r_addr == 16'hFE02);

   always_comb begin
      w_rd_data = r_mem[w_acc_addr[MEM_ADDR_BITS-1:0]];
      if (w_acc_dev) begin
         case (w_acc_addr)
            16'hFE00: w_rd_data = {r_kb_full, 15'b0};
            16'hFE02: w_rd_data = {8'b0, r_kb_data};
            16'hFE04: w_rd_data = {i_Disp_ready, 15'b0};
            default:  w_rd_data = '0;
         endcase
      end
   end

   // A character arriving as KBDR is consumed replaces it and keeps the buffer full.
   always_ff @(posedge i_clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_kb_full <= 1'b0;
         r_kb_data <= '0;
      end else if (i_KB_valid && (!r_kb_full || w_kb_clear)) begin
         r_kb_full <= 1'b1;
         r_kb_data <= i_KB_data;
      end else if (w_kb_clear) begin
         r_kb_full <= 1'b0;
      end
   end

   assign o_Disp_valid = (r_state == S_READY) && r_rw && (r_addr == 16'hFE06) && i_Disp_ready;
   assign o_Disp_data  = o_Disp_valid ? r_data[7:0] : 8'h00;
`else
   logic w_unused;

   assign w_commit  = (r_state == S_READY) && r_rw;
   assign w_rd_data = r_mem[w_acc_addr[MEM_ADDR_BITS-1:0]];
   assign w_unused  = &{1'b0, r_addr};
`endif

endmodule

// File: tb/tb_lc3_memory_responder.sv
// Bench for lc3_memory_responder: two instances (3 and 0 wait states) against an array model.
module tb_lc3_memory_responder;
   localparam int WS_A = 3;
   localparam int WS_B = 0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mio, rwv, rdy, busy;
   logic [15:0] mar [2];
   logic [15:0] mdr [2];
   logic [15:0] mdata [2];

   logic [15:0] model [2][1024];
   int          checks = 0;
   int          errors = 0;
   int          n;
   logic [15:0] rd;
   logic [15:0] pool [8];

   always #5 clk = ~clk;

`ifdef LC3_MMIO_EN
   logic       kbv, dispr;
   logic [7:0] kbd;
   logic [1:0] dvalid;
   logic [7:0] ddata [2];
   int         disp_cnt = 0;
   logic [7:0] disp_last = 8'h00;

   always @(negedge clk) begin
      if (dvalid[0]) begin
         disp_cnt++;
         disp_last = ddata[0];
      end
   end
`endif

   lc3_memory_responder #(.MEM_ADDR_BITS(10), .WAIT_STATES(WS_A)) dut_a (
      .i_clk(clk), .i_Reset_n(rst_n), .i_MIO_EN(mio[0]), .i_R_W(rwv[0]),
      .i_MAR(mar[0]), .i_MDR(mdr[0]), .o_Mem_Data(mdata[0]),
      .o_Ready_Bit(rdy[0]), .o_Busy(busy[0])
`ifdef LC3_MMIO_EN
      , .i_KB_valid(kbv), .i_KB_data(kbd), .i_Disp_ready(dispr),
      .o_Disp_valid(dvalid[0]), .o_Disp_data(ddata[0])
`endif
   );

   lc3_memory_responder #(.MEM_ADDR_BITS(10), .WAIT_STATES(WS_B)) dut_b (
      .i_clk(clk), .i_Reset_n(rst_n), .i_MIO_EN(mio[1]), .i_R_W(rwv[1]),
      .i_MAR(mar[1]), .i_MDR(mdr[1]), .o_Mem_Data(mdata[1]),
      .o_Ready_Bit(rdy[1]), .o_Busy(busy[1])
`ifdef LC3_MMIO_EN
      , .i_KB_valid(1'b0), .i_KB_data(8'h00), .i_Disp_ready(1'b0),
      .o_Disp_valid(dvalid[1]), .o_Disp_data(ddata[1])
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete access on instance sel; returns with the instance back in IDLE.
   task automatic access(input int sel, input logic w, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic keep, output logic [15:0] rdata);
      int k;
      int lat;
      logic dev;
      lat = (sel == 0) ? WS_A + 1 : WS_B + 1;
      dev = (addr[15:9] == 7'h7F);
      mio[sel] = 1'b1; rwv[sel] = w; mar[sel] = addr; mdr[sel] = wdata;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
         if (k == 1) chk("busy_after_accept", busy[sel], 1'b1);
      end while (!rdy[sel] && k < 40);
      chk("ready_latency", k, lat);
      rdata = mdata[sel];
      if (!w && !dev) chk("read_data", mdata[sel], model[sel][addr[9:0]]);
      if (w && !dev) model[sel][addr[9:0]] = wdata;
      if (!keep) mio[sel] = 1'b0;
      @(posedge clk); #1;
      if (!w) chk("read_hold", mdata[sel], rdata);
   endtask

   initial begin
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 1024; i++) model[s][i] = 16'h0000;
      pool[0] = 16'h000; pool[1] = 16'h001; pool[2] = 16'h3FF; pool[3] = 16'h100;
      pool[4] = 16'h200; pool[5] = 16'h155; pool[6] = 16'h2AA; pool[7] = 16'h010;
      rst_n = 1'b0; mio = '0; rwv = '0;
      for (int s = 0; s < 2; s++) begin mar[s] = '0; mdr[s] = '0; end
`ifdef LC3_MMIO_EN
      kbv = 1'b0; kbd = 8'h00; dispr = 1'b0;
`endif
      #12;
      for (int s = 0; s < 2; s++) begin
         chk("reset_ready", rdy[s], 1'b0);
         chk("reset_busy", busy[s], 1'b0);
         chk("reset_data", mdata[s], 16'h0000);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      access(0, 1'b1, 16'h3000, 16'h1234, 1'b0, rd);
      access(0, 1'b0, 16'h3000, 16'h0000, 1'b1, rd);
      chk("rd_x3000", rd, 16'h1234);
      // Request still held after READY: a second identical read starts from this IDLE cycle.
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!rdy[0] && n < 40);
      chk("b2b_latency", n, WS_A + 1);
      chk("b2b_data", mdata[0], 16'h1234);
      mio[0] = 1'b0;
      @(posedge clk); #1;

      access(0, 1'b1, 16'h0400, 16'hAAAA, 1'b0, rd);
      access(0, 1'b0, 16'h0000, 16'h0000, 1'b0, rd);
      chk("alias_wrap", rd, 16'hAAAA);

      access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, rd);
      chk("ws0_zeroed", rd, 16'h0000);
      access(1, 1'b1, 16'h0010, 16'h5A5A, 1'b0, rd);
      access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, rd);
      chk("ws0_readback", rd, 16'h5A5A);

      access(0, 1'b1, 16'h0200, 16'h1111, 1'b0, rd);
      mio[0] = 1'b1; rwv[0] = 1'b1; mar[0] = 16'h0200; mdr[0] = 16'hBEEF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_busy_wait", busy[0], 1'b1);
      mio[0] = 1'b0;
      n = 0;
      repeat (6) begin @(posedge clk); #1; if (rdy[0]) n++; end
      chk("abort_no_ready", n, 0);
      chk("abort_idle", busy[0], 1'b0);
      access(0, 1'b0, 16'h0200, 16'h0000, 1'b0, rd);
      chk("abort_old_value", rd, 16'h1111);

      mio[0] = 1'b1; rwv[0] = 1'b1; mar[0] = 16'h0055; mdr[0] = 16'hCAFE;
      @(posedge clk); #1;
      mar[0] = 16'h0066; mdr[0] = 16'h0BAD; rwv[0] = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!rdy[0] && n < 40);
      chk("latched_latency", n, WS_A);
      mio[0] = 1'b0;
      @(posedge clk); #1;
      model[0][16'h055] = 16'hCAFE;
      access(0, 1'b0, 16'h0055, 16'h0000, 1'b0, rd);
      access(0, 1'b0, 16'h0066, 16'h0000, 1'b0, rd);

      access(0, 1'b1, 16'h0123, 16'h4444, 1'b0, rd);
      mio[0] = 1'b1; rwv[0] = 1'b1; mar[0] = 16'h0123; mdr[0] = 16'h7777;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", rdy[0], 1'b0);
      chk("rst_mid_busy", busy[0], 1'b0);
      chk("rst_mid_data", mdata[0], 16'h0000);
      mio[0] = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      access(0, 1'b0, 16'h0123, 16'h0000, 1'b0, rd);
      chk("rst_no_write", rd, 16'h4444);

      for (int t = 0; t < 40; t++) begin
         int          sel;
         logic        w;
         logic [15:0] a;
         sel = int'($urandom_range(0, 1));
         w   = 1'($urandom_range(0, 1));
         a   = {6'($urandom_range(0, 62)), pool[$urandom_range(0, 7)][9:0]};
         access(sel, w, a, 16'($urandom), 1'b0, rd);
      end

`ifdef LC3_MMIO_EN
      kbd = 8'h41; kbv = 1'b1;
      @(posedge clk); #1;
      kbv = 1'b0;
      access(0, 1'b0, 16'hFE00, 16'h0000, 1'b0, rd);
      chk("kbsr_full", rd, 16'h8000);
      access(0, 1'b0, 16'hFE02, 16'h0000, 1'b0, rd);
      chk("kbdr_data", rd, 16'h0041);
      access(0, 1'b0, 16'hFE00, 16'h0000, 1'b0, rd);
      chk("kbsr_empty", rd, 16'h0000);
      dispr = 1'b1;
      access(0, 1'b0, 16'hFE04, 16'h0000, 1'b0, rd);
      chk("dsr_ready", rd, 16'h8000);
      access(0, 1'b1, 16'hFE06, 16'h0058, 1'b0, rd);
      chk("ddr_pulses", disp_cnt, 1);
      chk("ddr_data", disp_last, 8'h58);
      dispr = 1'b0;
      access(0, 1'b1, 16'hFE06, 16'h0059, 1'b0, rd);
      chk("ddr_dropped", disp_cnt, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
